// File: rtl/square_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : square_channel_ctrl
// Brief    : Square-voice sequencer: duty step strobe, duty select register,
//            length counter and volume envelope driven by a 512 Hz frame strobe.
// Revision : 1.0 - initial release
// ============================================================================
module square_channel_ctrl #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [10:0] freq,
    input  logic [1:0]  duty_in,
    input  logic [5:0]  length_load,
    input  logic        length_en,
    input  logic [3:0]  env_init,
    input  logic        env_dir,
    input  logic [2:0]  env_period,
    input  logic        frame_tick,
    output logic        duty_step,
    output logic [1:0]  duty_cycle,
    output logic [3:0]  volume,
    output logic        active
);

    localparam int          c_PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [10:0] c_TIMER_TOP = 11'h7FF;
    localparam logic [6:0]  c_LEN_FULL  = 7'd64;

    logic        r_active;
    logic [3:0]  r_volume;
    logic [1:0]  r_duty_cycle;
    logic        r_duty_step;
    logic [10:0] r_timer;
    logic [6:0]  r_length;
    logic [2:0]  r_env_timer;
    logic [2:0]  r_frame_step;

    logic        w_ps_wrap;
    logic        w_dac_on;
    logic        w_timer_wrap;
    logic        w_len_clk;
    logic        w_env_clk;
    logic        w_len_dec;
    logic        w_len_expire;
    logic        w_env_active;
    logic        w_env_reload;
    logic [3:0]  w_vol_next;

    // With a prescale of one every clock is a timer tick, so no counter is kept.
    generate
        if (PRESCALE > 1) begin : g_ps_multi
            localparam logic [c_PW-1:0] c_PS_LAST = c_PW'(PRESCALE - 1);
            logic [c_PW-1:0] r_prescale;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prescale <= '0;
                end else if (trigger) begin
                    r_prescale <= '0;
                end else if (r_active) begin
                    r_prescale <= (r_prescale == c_PS_LAST) ? '0 : r_prescale + 1'b1;
                end
            end

            assign w_ps_wrap = (r_prescale == c_PS_LAST);
        end else begin : g_ps_single
            assign w_ps_wrap = 1'b1;
        end
    endgenerate

    assign w_dac_on     = (env_init != 4'd0) || env_dir;
    assign w_timer_wrap = r_active && w_ps_wrap && (r_timer == c_TIMER_TOP);

    // Frame actions key off the step value before this tick advances it.
    assign w_len_clk    = frame_tick && !r_frame_step[0];
    assign w_env_clk    = frame_tick && (r_frame_step == 3'd7);
    assign w_len_dec    = w_len_clk && length_en && (r_length != 7'd0);
    assign w_len_expire = w_len_dec && (r_length == 7'd1);
    assign w_env_active = w_env_clk && (env_period != 3'd0);
    assign w_env_reload = w_env_active && (r_env_timer <= 3'd1);

    always_comb begin
        w_vol_next = r_volume;
        if (env_dir) begin
            if (r_volume != 4'd15) begin
                w_vol_next = r_volume + 4'd1;
            end
        end else begin
            if (r_volume != 4'd0) begin
                w_vol_next = r_volume - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= 1'b0;
            r_volume     <= 4'd0;
            r_duty_cycle <= 2'd0;
            r_duty_step  <= 1'b0;
            r_timer      <= 11'd0;
            r_length     <= 7'd0;
            r_env_timer  <= 3'd0;
            r_frame_step <= 3'd0;
        end else begin
            r_duty_cycle <= duty_in;

            if (frame_tick) begin
                r_frame_step <= r_frame_step + 3'd1;
            end

            if (trigger) begin
                // A trigger overrides any coincident length or envelope clock.
                r_active    <= w_dac_on;
                r_timer     <= freq;
                r_volume    <= env_init;
                r_env_timer <= env_period;
                r_length    <= c_LEN_FULL - {1'b0, length_load};
                r_duty_step <= 1'b0;
            end else begin
                // Suppress the strobe when the channel shuts off on this edge.
                r_duty_step <= w_timer_wrap && !w_len_expire;

                if (r_active && w_ps_wrap) begin
                    r_timer <= (r_timer == c_TIMER_TOP) ? freq : r_timer + 11'd1;
                end

                if (w_len_dec) begin
                    r_length <= r_length - 7'd1;
                    if (w_len_expire) begin
                        r_active <= 1'b0;
                    end
                end

                if (w_env_active) begin
                    if (w_env_reload) begin
                        r_env_timer <= env_period;
                        r_volume    <= w_vol_next;
                    end else begin
                        r_env_timer <= r_env_timer - 3'd1;
                    end
                end
            end
        end
    end

    assign duty_step  = r_duty_step;
    assign duty_cycle = r_duty_cycle;
    assign volume     = r_volume;
    assign active     = r_active;

endmodule
`default_nettype wire

// File: tb/tb_square_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_channel_ctrl
// Brief    : Directed bench for square_channel_ctrl (PRESCALE = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_channel_ctrl;

    localparam int c_PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic [10:0] freq = 11'd0;
    logic [1:0]  duty_in = 2'd0;
    logic [5:0]  length_load = 6'd0;
    logic        length_en = 1'b0;
    logic [3:0]  env_init = 4'd0;
    logic        env_dir = 1'b0;
    logic [2:0]  env_period = 3'd0;
    logic        frame_tick = 1'b0;
    logic        duty_step;
    logic [1:0]  duty_cycle;
    logic [3:0]  volume;
    logic        active;

    int tests  = 0;
    int errors = 0;

    square_channel_ctrl #(.PRESCALE(c_PRESCALE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger     (trigger),
        .freq        (freq),
        .duty_in     (duty_in),
        .length_load (length_load),
        .length_en   (length_en),
        .env_init    (env_init),
        .env_dir     (env_dir),
        .env_period  (env_period),
        .frame_tick  (frame_tick),
        .duty_step   (duty_step),
        .duty_cycle  (duty_cycle),
        .volume      (volume),
        .active      (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] freq;
        logic [1:0]  duty;
        logic [3:0]  env_init;
        logic        env_dir;
        logic        exp_active;
        logic [3:0]  exp_volume;
        int          exp_first;   // clocks from trigger edge to first strobe; 0 = none
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic fire_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Clocks until duty_step reads high; -1 when the bound expires.
    task automatic wait_strobe(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!duty_step && n < bound);
        if (!duty_step) n = -1;
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (duty_step) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;

        vecs[0] = '{11'd2047, 2'd2, 4'd8,  1'b0, 1'b1, 4'd8,  4};
        vecs[1] = '{11'd2044, 2'd1, 4'd15, 1'b0, 1'b1, 4'd15, 16};
        vecs[2] = '{11'd2040, 2'd3, 4'd0,  1'b1, 1'b1, 4'd0,  32};
        vecs[3] = '{11'd2000, 2'd0, 4'd5,  1'b0, 1'b1, 4'd5,  192};
        vecs[4] = '{11'd2047, 2'd1, 4'd0,  1'b0, 1'b0, 4'd0,  0};

        do_reset();
        chk("reset_active", active, 0);
        chk("reset_volume", volume, 0);
        chk("reset_duty_cycle", duty_cycle, 0);
        chk("reset_duty_step", duty_step, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            freq     = vecs[v].freq;
            duty_in  = vecs[v].duty;
            env_init = vecs[v].env_init;
            env_dir  = vecs[v].env_dir;
            fire_trigger();
            chk($sformatf("vec%0d_active", v), active, vecs[v].exp_active);
            chk($sformatf("vec%0d_volume", v), volume, vecs[v].exp_volume);
            chk($sformatf("vec%0d_duty_cycle", v), duty_cycle, vecs[v].duty);
            if (vecs[v].exp_first == 0) begin
                count_strobes(64, cnt);
                chk($sformatf("vec%0d_no_strobe", v), cnt, 0);
            end else begin
                wait_strobe(vecs[v].exp_first + 20, n);
                chk($sformatf("vec%0d_first", v), n, vecs[v].exp_first);
                wait_strobe(vecs[v].exp_first + 20, n);
                chk($sformatf("vec%0d_period", v), n, vecs[v].exp_first);
            end
        end

        // Live duty select follows with one clock of latency, no trigger needed.
        duty_in = 2'd3;
        step();
        chk("duty_live", duty_cycle, 3);

        // Frequency change mid-period lands at the next reload.
        do_reset();
        freq = 11'd2044;
        env_init = 4'd8;
        fire_trigger();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (duty_step) cnt++;
        end
        freq = 11'd2046;
        wait_strobe(40, n);
        chk("fchg_first", (n < 0) ? -1 : n + 4 + cnt * 1000, 16);
        wait_strobe(40, n);
        chk("fchg_second", n, 8);
        wait_strobe(40, n);
        chk("fchg_third", n, 8);

        // Length expiry after two even-step frame ticks.
        do_reset();
        freq = 11'd2047;
        env_init = 4'd8;
        length_en = 1'b1;
        length_load = 6'd62;
        fire_trigger();
        frame();
        chk("len_after_step0", active, 1);
        frame();
        chk("len_after_step1", active, 1);
        frame();
        chk("len_after_step2", active, 0);
        chk("len_step_low", duty_step, 0);
        count_strobes(20, cnt);
        chk("len_strobes_stop", cnt, 0);
        chk("len_volume_hold", volume, 8);

        // Trigger coincident with a length clock: loads win.
        do_reset();
        length_en = 1'b1;
        length_load = 6'd62;
        env_init = 4'd8;
        trigger = 1'b1;
        frame_tick = 1'b1;
        step();
        trigger = 1'b0;
        frame_tick = 1'b0;
        frame();
        frame();
        chk("coinc_after_step2", active, 1);
        frame();
        frame();
        chk("coinc_after_step4", active, 0);

        // Envelope decay saturating at zero.
        do_reset();
        length_en = 1'b0;
        env_init = 4'd2;
        env_dir = 1'b0;
        env_period = 3'd1;
        fire_trigger();
        for (int i = 0; i < 7; i++) frame();
        chk("env_dn_before7", volume, 2);
        frame();
        chk("env_dn_1", volume, 1);
        for (int i = 0; i < 8; i++) frame();
        chk("env_dn_0", volume, 0);
        for (int i = 0; i < 8; i++) frame();
        chk("env_dn_sat", volume, 0);

        // Envelope rise saturating at fifteen.
        do_reset();
        env_init = 4'd14;
        env_dir = 1'b1;
        env_period = 3'd1;
        fire_trigger();
        for (int i = 0; i < 8; i++) frame();
        chk("env_up_15", volume, 15);
        for (int i = 0; i < 8; i++) frame();
        chk("env_up_sat", volume, 15);

        // Period 2: first step-7 only counts the timer down.
        do_reset();
        env_init = 4'd8;
        env_dir = 1'b0;
        env_period = 3'd2;
        fire_trigger();
        for (int i = 0; i < 8; i++) frame();
        chk("env_p2_first", volume, 8);
        for (int i = 0; i < 8; i++) frame();
        chk("env_p2_second", volume, 7);
        env_period = 3'd0;

        // Asynchronous reset while strobing.
        do_reset();
        freq = 11'd2047;
        env_init = 4'd9;
        duty_in = 2'd2;
        fire_trigger();
        for (int i = 0; i < 6; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_active", active, 0);
        chk("arst_volume", volume, 0);
        chk("arst_duty_cycle", duty_cycle, 0);
        chk("arst_duty_step", duty_step, 0);
        step();
        rst_n = 1'b1;
        count_strobes(20, cnt);
        chk("arst_no_strobe", cnt, 0);
        chk("arst_stay_inactive", active, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_channel_ctrl.md
# square_channel_ctrl

Sequencer for one square-wave voice: generates the single-cycle step strobe that advances the duty cycler, registers its duty selection, and runs the channel's length counter and volume envelope. Sits between the register file (trigger/config inputs) and the duty cycler/mixer. The channel is clocked from the system clock, and frame-sequencer timing arrives as a 512 Hz strobe.

## Interface
- PRESCALE, default 4: system clocks per frequency-timer tick. Must be ≥1.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- trigger  in  1  one-cycle pulse; (re)starts the channel and loads configuration
- freq  in  11  frequency register; step period = (2048−freq)×PRESCALE clocks
- duty_in  in  2  duty select (0=12.5%, 1=25%, 2=50%, 3=75%)
- length_load  in  6  length value; remaining = 64−length_load
- length_en  in  1  length counter enabled
- env_init  in  4  initial volume
- env_dir  in  1  1=increase, 0=decrease
- env_period  in  3  envelope period in envelope clocks; 0 = envelope frozen
- frame_tick  in  1  one-cycle 512 Hz strobe
- duty_step  out  1  one-cycle strobe; duty cycler advances one position
- duty_cycle  out  2  registered duty select to the duty cycler
- volume  out  4  current envelope volume
- active  out  1  channel enabled

## Operation
- Reset (async): active=0, volume=0, duty_cycle=0, duty_step=0, prescaler=0, timer=0, length remaining=0, env timer=0, frame step=0.
- duty_cycle <= duty_in every cycle; changes are live and do not require a trigger.
- Trigger: active<=1 unless env_init==0 && env_dir==0 (DAC off → active<=0). Also: timer<=freq, prescaler<=0, volume<=env_init, env timer<=env_period, and length remaining<=64−length_load (7-bit; length_load=0 gives 64).
- Frequency timer runs only while active. The prescaler counts 0..PRESCALE−1. On wrap, timer increments. If the timer is 2047 at the wrap, the timer reloads from the current freq and duty_step<=1 for one cycle. A freq change therefore takes effect at the next reload.
- Frame step counter: 3-bit, advances on every frame_tick, wraps 7→0. Actions use the pre-increment value.
  - Length clock on even steps (0, 2, 4, 6). If length_en and remaining>0, decrement remaining. Reaching 0 forces active<=0.
  - Envelope clock on step 7. If env_period==0, no change. Otherwise:
    - If the env timer is ≤1, reload it with env_period and step the volume ±1, saturating at 15 (up) or 0 (down).
    - Otherwise, decrement the env timer.
- Envelope and length counters run regardless of active.
- trigger and frame_tick in the same cycle: trigger loads win; the frame step counter still advances.
- Re-trigger while active: full restart as above, with no duty_step in that cycle.
- When active falls, duty_step stops in the same cycle that active reads 0. Volume holds its value.

## Timing
- All outputs are registered; no combinational input→output paths.
- Trigger sampled at edge T: active and volume are valid in cycle T+1.
- First duty_step is high in cycle T+(2048−freq)×PRESCALE+1. Later strobes follow every (2048−freq)×PRESCALE cycles.
- freq=2047 with PRESCALE=1 gives duty_step high every cycle.
- Length expiry: active=0 in the cycle after the frame_tick that decremented remaining to 0.
- duty_cycle follows duty_in with 1-cycle latency.

## Test plan
- Reset mid-run (rst_n low while duty_step is pulsing) → all outputs 0 immediately and remain 0 until the next trigger.
- PRESCALE=4, freq=2047, env_init=8, trigger at T → active=1 at T+1, duty_step first high at T+5 and then every 4 cycles.
- freq=2044 at trigger, changed to 2046 mid-period → first period 16 cycles, subsequent periods 8 cycles.
- length_en=1, length_load=62 → remaining=2; two even-step frame_ticks → active=0 the cycle after the second; duty_step ceases.
- env_init=2, env_dir=0, env_period=1 → volume 2→1→0 on successive step-7 frame_ticks, then stays at 0. env_init=14, env_dir=1 saturates at 15.
- env_init=0, env_dir=0 trigger → active stays 0. Trigger coincident with a length-decrementing frame_tick → remaining equals 64−length_load, not minus 1.
